upc_tag_transmitter: RTL and testbench

//  Serial encoder for the package tag read by the UPC detector. It accepts a 4-bit item code
//  {M,U,P,C}, rejects codes that are not catalogued items, and shifts a framed, parity-protected
//  tag onto a single line (tx). It sits on the tag/scanner side of the checkout link, driven by
//  SW-level code inputs.

---
 rtl/upc_tag_transmitter_pkg.sv | 32 +++
 rtl/upc_tag_transmitter_bit_timer.sv | 36 +++
 rtl/upc_tag_transmitter.sv | 136 +++++++++++++
 tb/tb_upc_tag_transmitter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/upc_tag_transmitter_pkg.sv
// Shared definitions for the UPC tag transmitter.
// Holds the catalogued item codes, the serial FSM state encoding, the frame
// length in bits and the helper that decides whether an item code is valid.
package upc_tag_transmitter_pkg;

    localparam logic [3:0] ITEM_GLASSES = 4'd0;
    localparam logic [3:0] ITEM_TOPHAT  = 4'd1;
    localparam logic [3:0] ITEM_WATER   = 4'd3;
    localparam logic [3:0] ITEM_PISTOL  = 4'd4;
    localparam logic [3:0] ITEM_GAS     = 4'd5;
    localparam logic [3:0] ITEM_SHIRT   = 4'd6;

    // start, M, U, P, C, parity, stop
    localparam int FRAME_BITS = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic logic is_valid_code(input logic [3:0] code);
        case (code)
            ITEM_GLASSES, ITEM_TOPHAT, ITEM_WATER,
            ITEM_PISTOL, ITEM_GAS, ITEM_SHIRT: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/upc_tag_transmitter_bit_timer.sv
// Bit-period timer for the UPC tag transmitter.
// Counts 0..BIT_CYCLES-1 while enabled and wraps on terminal count.
// Ports:
//   clk     in  clock
//   clear   in  synchronous clear, forces the count to 0
//   enable  in  advance the count this cycle
//   tc      out terminal count (last cycle of a bit period)
//   pre_tc  out count is one short of terminal; lets the caller register
//               an output that must line up with the terminal cycle
module upc_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic tc,
    output logic pre_tc
);

    localparam logic [7:0] LAST     = 8'(BIT_CYCLES - 1);
    localparam logic [7:0] PRE_LAST = 8'(BIT_CYCLES - 2);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= tc ? 8'd0 : count + 8'd1;
        end
    end

    assign tc     = enable && (count == LAST);
    assign pre_tc = enable && (count == PRE_LAST);

endmodule

// File: rtl/upc_tag_transmitter.sv
// UPC tag transmitter: accepts a 4-bit item code {M,U,P,C}, rejects codes
// that are not catalogued items, and shifts out a framed, parity-protected
// tag: start(0), M, U, P, C, parity, stop(1), each held BIT_CYCLES cycles.
// Ports:
//   CLOCK_50 in  system clock
//   reset    in  synchronous active-high reset
//   code     in  item code {M,U,P,C}
//   send     in  request, accepted when ready=1
//   ready    out high only while idle
//   tx       out serial line, idles high
//   busy     out high from start bit through stop bit
//   done     out one-cycle pulse on the final stop-bit cycle
//   err      out one-cycle pulse after a request with an invalid code
module upc_tag_transmitter
    import upc_tag_transmitter_pkg::*;
#(
    parameter int BIT_CYCLES = 4,
    parameter int ODD_PARITY = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] code,
    input  logic       send,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    tx_state_t  state;
    tx_state_t  state_next;
    logic [1:0] idx;
    logic [1:0] idx_next;
    logic [3:0] data_q;
    logic       parity_q;
    logic       tx_next;
    logic       accept;
    logic       reject;
    logic       tc;
    logic       pre_tc;
    logic       timer_clear;

    assign accept      = (state == ST_IDLE) && send && is_valid_code(code);
    assign reject      = (state == ST_IDLE) && send && !is_valid_code(code);
    assign timer_clear = reset || (state == ST_IDLE);

    upc_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk   (CLOCK_50),
        .clear (timer_clear),
        .enable(state != ST_IDLE),
        .tc    (tc),
        .pre_tc(pre_tc)
    );

    // Next state and the tx value for the next cycle. tx is decoded from the
    // upcoming state so the line itself can be a plain register.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tc) begin
                    state_next = ST_DATA;
                    idx_next   = 2'd3;
                end
            end
            ST_DATA: begin
                if (tc) begin
                    if (idx == 2'd0) begin
                        state_next = ST_PARITY;
                    end else begin
                        idx_next = idx - 2'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tc) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tc) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = data_q[idx_next];
            ST_PARITY: tx_next = parity_q;
            default:   tx_next = 1'b1;
        endcase
    end

    // State, latched code and registered outputs. done is set one cycle early
    // (pre_tc) so that the registered pulse lands on the final stop cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            data_q   <= 4'd0;
            parity_q <= 1'b0;
            tx       <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (accept) begin
                data_q   <= code;
                parity_q <= (ODD_PARITY != 0) ? ~^code : ^code;
            end
            tx    <= tx_next;
            ready <= (state_next == ST_IDLE);
            busy  <= (state_next != ST_IDLE);
            done  <= (state == ST_STOP) && pre_tc;
            err   <= reject;
        end
    end

endmodule

// File: tb/tb_upc_tag_transmitter.sv
// Self-checking bench for upc_tag_transmitter. Two instances share clock and
// reset: index 0 uses even parity, index 1 odd parity. A cycle-level model
// tracks each instance as "position within the frame" and derives every
// output from the frame layout; literal expectations pin the model.
module tb_upc_tag_transmitter;

    localparam int BC        = 4;
    localparam int FRAME_LEN = 7 * BC;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] code_a [2];
    logic       send_a [2];
    logic       ready_a[2];
    logic       tx_a   [2];
    logic       busy_a [2];
    logic       done_a [2];
    logic       err_a  [2];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    upc_tag_transmitter #(.BIT_CYCLES(BC), .ODD_PARITY(0)) dut_even (
        .CLOCK_50(clk),
        .reset   (reset),
        .code    (code_a[0]),
        .send    (send_a[0]),
        .ready   (ready_a[0]),
        .tx      (tx_a[0]),
        .busy    (busy_a[0]),
        .done    (done_a[0]),
        .err     (err_a[0])
    );

    upc_tag_transmitter #(.BIT_CYCLES(BC), .ODD_PARITY(1)) dut_odd (
        .CLOCK_50(clk),
        .reset   (reset),
        .code    (code_a[1]),
        .send    (send_a[1]),
        .ready   (ready_a[1]),
        .tx      (tx_a[1]),
        .busy    (busy_a[1]),
        .done    (done_a[1]),
        .err     (err_a[1])
    );

    // Model: pos is 0 when idle, otherwise k for the k-th cycle of a frame.
    int         pos     [2] = '{0, 0};
    logic [3:0] mcode   [2] = '{4'd0, 4'd0};
    logic       merr    [2] = '{1'b0, 1'b0};
    int         pos_n   [2];
    logic [3:0] mcode_n [2];
    logic       merr_n  [2];
    logic       model_live = 1'b0;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pos_n[i]   = pos[i];
            mcode_n[i] = mcode[i];
            merr_n[i]  = 1'b0;
            if (reset) begin
                pos_n[i] = 0;
            end else if (pos[i] == 0) begin
                if (send_a[i]) begin
                    if (code_a[i] inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6}) begin
                        pos_n[i]   = 1;
                        mcode_n[i] = code_a[i];
                    end else begin
                        merr_n[i] = 1'b1;
                    end
                end
            end else if (pos[i] == FRAME_LEN) begin
                pos_n[i] = 0;
            end else begin
                pos_n[i] = pos[i] + 1;
            end
        end
    end

    always @(posedge clk) begin
        pos   <= pos_n;
        mcode <= mcode_n;
        merr  <= merr_n;
        if (reset) begin
            model_live <= 1'b1;
        end
    end

    function automatic int exp_tx(input int p, input logic [3:0] c, input int odd);
        int b;
        int ones;
        if (p == 0) return 1;
        b = (p - 1) / BC;
        ones = 0;
        for (int j = 0; j < 4; j++) ones += int'(c[j]);
        case (b)
            0:       return 0;
            1:       return int'(c[3]);
            2:       return int'(c[2]);
            3:       return int'(c[1]);
            4:       return int'(c[0]);
            5:       return (ones + odd) % 2;
            default: return 1;
        endcase
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                check_output($sformatf("cyc tx%0d", i),    int'(tx_a[i]),    exp_tx(pos[i], mcode[i], i));
                check_output($sformatf("cyc ready%0d", i), int'(ready_a[i]), int'(pos[i] == 0));
                check_output($sformatf("cyc busy%0d", i),  int'(busy_a[i]),  int'(pos[i] != 0));
                check_output($sformatf("cyc done%0d", i),  int'(done_a[i]),  int'(pos[i] == FRAME_LEN));
                check_output($sformatf("cyc err%0d", i),   int'(err_a[i]),   int'(merr[i]));
            end
        end
    end

    task automatic apply_stimulus(input int i, input logic [3:0] c, input logic s);
        code_a[i] = c;
        send_a[i] = s;
    endtask

    // Walks the 29 cycles following an acceptance of instance 0. Samples each
    // bit mid-period for both instances and gathers frame statistics.
    task automatic capture_frame(input logic hold, input int chg_at, input logic [3:0] chg_code,
                                 input int pulse_at,
                                 output logic [6:0] bits0, output logic [6:0] bits1,
                                 output int busy_n, output int done_at,
                                 output logic rdy29, output logic tx29, output logic err_seen);
        busy_n   = 0;
        done_at  = -1;
        err_seen = 1'b0;
        bits0    = '0;
        bits1    = '0;
        rdy29    = 1'b0;
        tx29     = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            if (!hold && (k == 1 || k == pulse_at + 1)) send_a[0] = 1'b0;
            if (k == chg_at) code_a[0] = chg_code;
            if (k == pulse_at) send_a[0] = 1'b1;
            if (busy_a[0]) busy_n++;
            if (err_a[0]) err_seen = 1'b1;
            if (done_a[0] && done_at < 0) done_at = k;
            if ((k % BC) == 2 && k <= FRAME_LEN) begin
                bits0[6 - (k - 2) / BC] = tx_a[0];
                bits1[6 - (k - 2) / BC] = tx_a[1];
            end
            if (k == 29) begin
                rdy29 = ready_a[0];
                tx29  = tx_a[0];
            end
        end
    endtask

    initial begin
        logic [6:0] b0;
        logic [6:0] b1;
        int         bn;
        int         dn;
        logic       r29;
        logic       t29;
        logic       es;
        logic [3:0] bad_codes [3];
        logic [3:0] tbl_code  [3];
        logic [6:0] tbl_bits  [3];

        bad_codes = '{4'd2, 4'd7, 4'd15};
        tbl_code  = '{4'd0, 4'd3, 4'd4};
        tbl_bits  = '{7'b0000001, 7'b0001101, 7'b0010011};

        reset = 1'b1;
        apply_stimulus(0, 4'd0, 1'b0);
        apply_stimulus(1, 4'd0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst tx", int'(tx_a[0]), 1);
        check_output("rst ready", int'(ready_a[0]), 1);
        check_output("rst busy", int'(busy_a[0]), 0);
        check_output("rst done", int'(done_a[0]), 0);
        check_output("rst err", int'(err_a[0]), 0);
        reset = 1'b0;

        // Single frame, code 1
        apply_stimulus(0, 4'b0001, 1'b1);
        capture_frame(1'b0, 0, 4'd0, 0, b0, b1, bn, dn, r29, t29, es);
        check_output("code1 bits", int'(b0), int'(7'b0000111));
        check_output("code1 busy cycles", bn, 28);
        check_output("code1 done cycle", dn, 28);
        check_output("code1 ready29", int'(r29), 1);

        // Invalid codes
        foreach (bad_codes[n]) begin
            apply_stimulus(0, bad_codes[n], 1'b1);
            @(negedge clk);
            send_a[0] = 1'b0;
            check_output("bad err pulse", int'(err_a[0]), 1);
            check_output("bad tx", int'(tx_a[0]), 1);
            check_output("bad ready", int'(ready_a[0]), 1);
            @(negedge clk);
            check_output("bad err clear", int'(err_a[0]), 0);
            check_output("bad ready after", int'(ready_a[0]), 1);
        end

        // Code change and send while busy are ignored
        apply_stimulus(0, 4'd6, 1'b1);
        capture_frame(1'b0, 5, 4'd4, 10, b0, b1, bn, dn, r29, t29, es);
        check_output("latch bits", int'(b0), int'(7'b0011001));
        check_output("latch no err", int'(es), 0);
        check_output("latch busy cycles", bn, 28);

        // Further valid codes
        foreach (tbl_code[n]) begin
            apply_stimulus(0, tbl_code[n], 1'b1);
            capture_frame(1'b0, 0, 4'd0, 0, b0, b1, bn, dn, r29, t29, es);
            check_output($sformatf("table code%0d bits", tbl_code[n]), int'(b0), int'(tbl_bits[n]));
        end

        // Reset mid-frame, then a fresh full frame
        apply_stimulus(0, 4'd3, 1'b1);
        @(negedge clk);
        send_a[0] = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("midrst tx", int'(tx_a[0]), 1);
        check_output("midrst ready", int'(ready_a[0]), 1);
        check_output("midrst busy", int'(busy_a[0]), 0);
        reset = 1'b0;
        apply_stimulus(0, 4'd3, 1'b1);
        capture_frame(1'b0, 0, 4'd0, 0, b0, b1, bn, dn, r29, t29, es);
        check_output("postrst busy cycles", bn, 28);
        check_output("postrst bits", int'(b0), int'(7'b0001101));

        // Reset wins over send in the same cycle
        reset = 1'b1;
        apply_stimulus(0, 4'd1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        send_a[0] = 1'b0;
        check_output("rst prio ready", int'(ready_a[0]), 1);
        check_output("rst prio busy", int'(busy_a[0]), 0);

        // Back-to-back frames with send held, both parities
        apply_stimulus(0, 4'd5, 1'b1);
        apply_stimulus(1, 4'd5, 1'b1);
        capture_frame(1'b1, 0, 4'd0, 0, b0, b1, bn, dn, r29, t29, es);
        check_output("b2b f1 even bits", int'(b0), int'(7'b0010101));
        check_output("b2b f1 odd bits", int'(b1), int'(7'b0010111));
        check_output("b2b gap tx", int'(t29), 1);
        check_output("b2b gap ready", int'(r29), 1);
        capture_frame(1'b1, 0, 4'd0, 0, b0, b1, bn, dn, r29, t29, es);
        check_output("b2b f2 even bits", int'(b0), int'(7'b0010101));
        check_output("b2b f2 odd bits", int'(b1), int'(7'b0010111));
        check_output("b2b f2 busy cycles", bn, 28);
        send_a[0] = 1'b0;
        send_a[1] = 1'b0;

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
